// File: rtl/rf_cmd_resp.sv
// RF-unit command responder: parses EB 90 command frames from the UART RX byte stream,
// applies set commands to the gain/frequency outputs and queues a 7-byte answer for UART TX.
//
// state    | meaning
// RX_H0    | hunting for first header byte
// RX_H1    | first header seen, expecting second (HDR0 again resyncs)
// RX_TYPE  | next byte is the command type
// RX_PAY   | collecting 6 payload bytes G3..G0 F1 F0
// RX_CSUM  | next byte is the checksum; frame completes on it
// TX_IDLE  | no answer in flight
// TX_SEND  | answer bytes being offered to the transmitter
module rf_cmd_resp #(
    parameter int unsigned TIMEOUT_CYC = 100000,
    parameter logic [7:0]  HDR0        = 8'hEB,
    parameter logic [7:0]  HDR1        = 8'h90
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_data_vld,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_data_vld,
    input  logic        i_tx_ready,
    output logic [31:0] o_rf_agin,
    output logic [15:0] o_rf_freq,
    output logic        o_rf_cfg_vld,
    output logic [31:0] o_frame_cnt,
    output logic [31:0] o_err_cnt,
    output logic [15:0] o_drop_cnt
);

    localparam int unsigned       TMO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {RX_H0, RX_H1, RX_TYPE, RX_PAY, RX_CSUM} rx_state_t;
    typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;

    rx_state_t        rx_state;
    tx_state_t        tx_state;
    logic [7:0]       type_r;
    logic [7:0]       sum_r;
    logic [47:0]      pay_r;
    logic [2:0]       pay_idx;
    logic [TMO_W-1:0] tmo_cnt;
    logic [47:0]      ans_sr;
    logic [2:0]       tx_idx;

    logic             frame_done;
    logic [7:0]       status;
    logic             do_apply;
    logic [15:0]      ans_freq;
    logic [7:0]       ans_type;
    logic [7:0]       ans_acs;

    always_comb begin
        frame_done = i_rx_data_vld && (rx_state == RX_CSUM);
        if (sum_r != i_rx_data)
            status = 8'h01;
        else if (type_r != 8'h01 && type_r != 8'h02)
            status = 8'h02;
        else
            status = 8'h00;
        do_apply = (type_r == 8'h01) && (status == 8'h00);
        // the answer reports the frequency as it will be after this frame
        ans_freq = do_apply ? pay_r[15:0] : o_rf_freq;
        ans_type = type_r | 8'h80;
        ans_acs  = ans_type + status + ans_freq[15:8] + ans_freq[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state     <= RX_H0;
            type_r       <= '0;
            sum_r        <= '0;
            pay_r        <= '0;
            pay_idx      <= '0;
            tmo_cnt      <= '0;
            o_rf_agin    <= '0;
            o_rf_freq    <= '0;
            o_rf_cfg_vld <= 1'b0;
            o_frame_cnt  <= '0;
            o_err_cnt    <= '0;
        end else begin
            o_rf_cfg_vld <= 1'b0;
            if (i_rx_data_vld) begin
                tmo_cnt <= '0;
                case (rx_state)
                    RX_H0: if (i_rx_data == HDR0) rx_state <= RX_H1;
                    RX_H1: begin
                        if (i_rx_data == HDR1)
                            rx_state <= RX_TYPE;
                        else if (i_rx_data != HDR0)
                            rx_state <= RX_H0;
                    end
                    RX_TYPE: begin
                        type_r   <= i_rx_data;
                        sum_r    <= i_rx_data;
                        pay_idx  <= '0;
                        rx_state <= RX_PAY;
                    end
                    RX_PAY: begin
                        pay_r <= {pay_r[39:0], i_rx_data};
                        sum_r <= sum_r + i_rx_data;
                        if (pay_idx == 3'd5)
                            rx_state <= RX_CSUM;
                        else
                            pay_idx <= pay_idx + 3'd1;
                    end
                    RX_CSUM: begin
                        rx_state    <= RX_H0;
                        o_frame_cnt <= o_frame_cnt + 32'd1;
                        if (status != 8'h00)
                            o_err_cnt <= o_err_cnt + 32'd1;
                        if (do_apply) begin
                            o_rf_agin    <= pay_r[47:16];
                            o_rf_freq    <= pay_r[15:0];
                            o_rf_cfg_vld <= 1'b1;
                        end
                    end
                    default: rx_state <= RX_H0;
                endcase
            end else if (rx_state != RX_H0) begin
                if (tmo_cnt == TMO_LAST) begin
                    tmo_cnt   <= '0;
                    rx_state  <= RX_H0;
                    o_err_cnt <= o_err_cnt + 32'd1;
                end else begin
                    tmo_cnt <= tmo_cnt + TMO_W'(1);
                end
            end else begin
                tmo_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state      <= TX_IDLE;
            o_tx_data     <= '0;
            o_tx_data_vld <= 1'b0;
            ans_sr        <= '0;
            tx_idx        <= '0;
            o_drop_cnt    <= '0;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (frame_done) begin
                        ans_sr        <= {HDR1, ans_type, status, ans_freq, ans_acs};
                        o_tx_data     <= HDR0;
                        o_tx_data_vld <= 1'b1;
                        tx_idx        <= '0;
                        tx_state      <= TX_SEND;
                    end
                end
                TX_SEND: begin
                    // a frame finishing while busy keeps its config effect but loses its answer
                    if (frame_done && o_drop_cnt != 16'hFFFF)
                        o_drop_cnt <= o_drop_cnt + 16'd1;
                    if (o_tx_data_vld && i_tx_ready) begin
                        if (tx_idx == 3'd6) begin
                            o_tx_data_vld <= 1'b0;
                            tx_state      <= TX_IDLE;
                        end else begin
                            o_tx_data <= ans_sr[47:40];
                            ans_sr    <= {ans_sr[39:0], 8'h00};
                            tx_idx    <= tx_idx + 3'd1;
                        end
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

endmodule
